pipeline_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RV32I pipeline. It drives the load and

---
 rtl/pipeline_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for a 5-stage RV32I pipeline.
//
// This block decides, each cycle, whether the pipeline advances. It drives the load and
// flush enables of every pipeline register and holds the instruction- and data-memory
// request handshakes until the matching response arrives. It also inserts load-use
// bubbles, squashes wrong-path instructions when MEM/WB redirects the PC, and keeps
// three saturating performance counters.
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   imem_resp, dmem_resp       1-cycle completion pulses from I-mem / D-mem
//   mem_req                    EX/MEM holds a load or store
//   redirect                   MEM/WB redirects the PC (jal, jalr, taken branch)
//   ex_is_load, ex_rd          ID/EX load flag and destination register
//   id_rs1/2, id_use_rs1/2     IF/ID source registers and their use qualifiers
//   imem_read, dmem_go         memory requests, held until the response arrives
//   load_*                     pipeline register load enables
//   flush_*                    load a NOP / invalid control word (only when loading)
//   stall_cnt, bubble_cnt, flush_cnt   saturating performance counters
module pipeline_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             imem_resp,
  input  logic             dmem_resp,
  input  logic             mem_req,
  input  logic             redirect,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  output logic             imem_read,
  output logic             dmem_go,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] StBoot      = 2'd0;
  localparam logic [1:0] StFetch     = 2'd1;
  localparam logic [1:0] StWaitMem   = 2'd2;
  localparam logic [1:0] StWaitFetch = 2'd3;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic             i_done_q, i_done_d;
  logic             d_done_q, d_done_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic running;
  logic i_hit;
  logic d_hit;
  logic f_ok;
  logic m_ok;
  logic advance;
  logic hazard;
  logic bubble;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == CntMax) ? cnt : cnt + CntOne;
  endfunction

  // Handshake and advance decision.
  always_comb begin
    running   = (state_q != StBoot);
    imem_read = running & ~i_done_q;
    dmem_go   = mem_req & running & ~d_done_q;
    // A response only counts while its request is outstanding; stray pulses are dropped.
    i_hit     = imem_resp & imem_read;
    d_hit     = dmem_resp & dmem_go;
    f_ok      = i_hit | i_done_q;
    m_ok      = ~mem_req | d_hit | d_done_q;
    advance   = running & f_ok & m_ok;

    hazard = ex_is_load & (ex_rd != 5'd0) &
             ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    // Redirect squashes the dependent instruction anyway, so it wins over the bubble.
    bubble = hazard & ~redirect;
  end

  // Register load / flush enables. Without advance everything freezes.
  always_comb begin
    load_pc      = advance & ~bubble;
    load_if_id   = advance & ~bubble;
    load_id_ex   = advance;
    load_ex_mem  = advance;
    load_mem_wb  = advance;
    flush_if_id  = advance & redirect;
    flush_id_ex  = advance & (redirect | bubble);
    flush_ex_mem = advance & redirect;
  end

  // Next state, done flags and counters.
  always_comb begin
    state_d      = state_q;
    i_done_d     = i_done_q;
    d_done_d     = d_done_q;
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;

    if (!running) begin
      state_d  = StFetch;
      i_done_d = 1'b0;
      d_done_d = 1'b0;
    end else if (advance) begin
      state_d  = StFetch;
      i_done_d = 1'b0;
      d_done_d = 1'b0;
      if (bubble) begin
        bubble_cnt_d = sat_inc(bubble_cnt_q);
      end
      if (redirect) begin
        flush_cnt_d = sat_inc(flush_cnt_q);
      end
    end else begin
      i_done_d    = i_done_q | i_hit;
      d_done_d    = d_done_q | d_hit;
      stall_cnt_d = sat_inc(stall_cnt_q);
      // Both flags set at once would have meant advance, so this is unambiguous.
      if (i_done_d) begin
        state_d = StWaitMem;
      end else if (d_done_d) begin
        state_d = StWaitFetch;
      end else begin
        state_d = StFetch;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StBoot;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl. A second instance with 4-bit counters shares the
// stimulus to exercise counter saturation.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_resp, dmem_resp, mem_req, redirect, ex_is_load;
  logic [4:0]  ex_rd, id_rs1, id_rs2;
  logic        id_use_rs1, id_use_rs2;

  logic        imem_read, dmem_go;
  logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic        flush_if_id, flush_id_ex, flush_ex_mem;
  logic [31:0] stall_cnt, bubble_cnt, flush_cnt;

  logic        s_imem_read, s_dmem_go;
  logic        s_load_pc, s_load_if_id, s_load_id_ex, s_load_ex_mem, s_load_mem_wb;
  logic        s_flush_if_id, s_flush_id_ex, s_flush_ex_mem;
  logic [3:0]  s_stall_cnt, s_bubble_cnt, s_flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_stall = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .imem_resp(imem_resp), .dmem_resp(dmem_resp),
    .mem_req(mem_req), .redirect(redirect), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .imem_read(imem_read), .dmem_go(dmem_go), .load_pc(load_pc), .load_if_id(load_if_id),
    .load_id_ex(load_id_ex), .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_ctrl #(.CNT_W(4)) u_dut_small (
    .clk(clk), .rst_n(rst_n), .imem_resp(imem_resp), .dmem_resp(dmem_resp),
    .mem_req(mem_req), .redirect(redirect), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .imem_read(s_imem_read), .dmem_go(s_dmem_go), .load_pc(s_load_pc),
    .load_if_id(s_load_if_id), .load_id_ex(s_load_id_ex), .load_ex_mem(s_load_ex_mem),
    .load_mem_wb(s_load_mem_wb), .flush_if_id(s_flush_if_id), .flush_id_ex(s_flush_id_ex),
    .flush_ex_mem(s_flush_ex_mem), .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt),
    .flush_cnt(s_flush_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // loads = {pc, if_id, id_ex, ex_mem, mem_wb}; flushes = {if_id, id_ex, ex_mem}
  task automatic chk_ctrl(input string tag, input logic [4:0] ld, input logic [2:0] fl);
    chk({tag, ".loads"}, {59'd0, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb},
        {59'd0, ld});
    chk({tag, ".flush"}, {61'd0, flush_if_id, flush_id_ex, flush_ex_mem}, {61'd0, fl});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    imem_resp = 1'b0; dmem_resp = 1'b0; mem_req = 1'b0; redirect = 1'b0;
    ex_is_load = 1'b0; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;

    // Reset state
    #3;
    chk("rst.imem_read", {63'd0, imem_read}, 64'd0);
    chk_ctrl("rst", 5'b00000, 3'b000);
    chk("rst.stall", {32'd0, stall_cnt}, 64'd0);
    tick();
    #2 rst_n = 1'b1;
    #1;
    chk("boot.imem_read", {63'd0, imem_read}, 64'd0);
    imem_resp = 1'b1;
    #1;
    chk_ctrl("boot.resp_ignored", 5'b00000, 3'b000);
    imem_resp = 1'b0;
    tick();
    chk("fetch.imem_read", {63'd0, imem_read}, 64'd1);
    chk("fetch.stall0", {32'd0, stall_cnt}, 64'd0);

    // 1: imem_resp every second cycle, mem_req=0
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_ctrl("t1.wait", 5'b00000, 3'b000);
      tick();
      exp_stall++;
      chk("t1.stall_inc", {32'd0, stall_cnt}, 64'(exp_stall));
      imem_resp = 1'b1;
      #1;
      chk_ctrl("t1.adv", 5'b11111, 3'b000);
      tick();
      imem_resp = 1'b0;
      chk("t1.stall_hold", {32'd0, stall_cnt}, 64'(exp_stall));
      chk("t1.imem_read", {63'd0, imem_read}, 64'd1);
    end

    // 2: fetch finishes first, memory later
    mem_req = 1'b1; imem_resp = 1'b1;
    #1;
    chk_ctrl("t2.c1", 5'b00000, 3'b000);
    chk("t2.c1.dmem_go", {63'd0, dmem_go}, 64'd1);
    tick();
    exp_stall++;
    imem_resp = 1'b0;
    #1;
    chk("t2.c2.imem_read", {63'd0, imem_read}, 64'd0);
    chk("t2.c2.dmem_go", {63'd0, dmem_go}, 64'd1);
    chk_ctrl("t2.c2", 5'b00000, 3'b000);
    tick();
    exp_stall++;
    dmem_resp = 1'b1;
    #1;
    chk_ctrl("t2.c3", 5'b11111, 3'b000);
    chk("t2.c3.imem_read", {63'd0, imem_read}, 64'd0);
    tick();
    chk("t2.stall", {32'd0, stall_cnt}, 64'(exp_stall));
    dmem_resp = 1'b0; mem_req = 1'b0;
    #1;
    chk("t2.refetch", {63'd0, imem_read}, 64'd1);

    // Stray dmem_resp with no request must not set d_done
    dmem_resp = 1'b1;
    tick();
    exp_stall++;
    dmem_resp = 1'b0; mem_req = 1'b1; imem_resp = 1'b1;
    #1;
    chk_ctrl("stray.no_adv", 5'b00000, 3'b000);
    chk("stray.dmem_go", {63'd0, dmem_go}, 64'd1);
    tick();
    exp_stall++;
    imem_resp = 1'b0; dmem_resp = 1'b1;
    #1;
    chk_ctrl("stray.adv", 5'b11111, 3'b000);
    tick();
    dmem_resp = 1'b0; mem_req = 1'b0;
    chk("stray.stall", {32'd0, stall_cnt}, 64'(exp_stall));

    // 3: load-use hazard on rs2
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1; imem_resp = 1'b1;
    #1;
    chk_ctrl("t3.hazard", 5'b00111, 3'b010);
    tick();
    chk("t3.bubble1", {32'd0, bubble_cnt}, 64'd1);
    imem_resp = 1'b0;
    #1;
    chk("t3.refetch", {63'd0, imem_read}, 64'd1);
    chk_ctrl("t3.freeze", 5'b00000, 3'b000);
    tick();
    exp_stall++;
    ex_rd = 5'd0; id_rs2 = 5'd0; imem_resp = 1'b1;
    #1;
    chk_ctrl("t3.x0", 5'b11111, 3'b000);
    tick();
    chk("t3.x0.bubble", {32'd0, bubble_cnt}, 64'd1);
    ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    #1;
    chk_ctrl("t3.unused_rs1", 5'b11111, 3'b000);
    tick();
    id_use_rs1 = 1'b1;
    #1;
    chk_ctrl("t3.rs1", 5'b00111, 3'b010);
    tick();
    chk("t3.bubble2", {32'd0, bubble_cnt}, 64'd2);

    // 4: redirect wins over hazard
    redirect = 1'b1;
    #1;
    chk_ctrl("t4.redirect", 5'b11111, 3'b111);
    tick();
    chk("t4.flush_cnt", {32'd0, flush_cnt}, 64'd1);
    chk("t4.bubble_same", {32'd0, bubble_cnt}, 64'd2);
    imem_resp = 1'b0;
    #1;
    chk_ctrl("t4.freeze", 5'b00000, 3'b000);
    tick();
    exp_stall++;
    chk("t4.flush_hold", {32'd0, flush_cnt}, 64'd1);
    chk("t4.stall", {32'd0, stall_cnt}, 64'(exp_stall));
    redirect = 1'b0; ex_is_load = 1'b0; id_use_rs1 = 1'b0;

    // 5: reset while in WAIT_FETCH
    mem_req = 1'b1; dmem_resp = 1'b1;
    #1;
    chk_ctrl("t5.stall", 5'b00000, 3'b000);
    tick();
    exp_stall++;
    dmem_resp = 1'b0;
    #1;
    chk("t5.wf.dmem_go", {63'd0, dmem_go}, 64'd0);
    chk("t5.wf.imem_read", {63'd0, imem_read}, 64'd1);
    chk("t5.wf.stall", {32'd0, stall_cnt}, 64'(exp_stall));
    rst_n = 1'b0;
    #1;
    chk("t5.rst.imem_read", {63'd0, imem_read}, 64'd0);
    chk("t5.rst.dmem_go", {63'd0, dmem_go}, 64'd0);
    chk("t5.rst.counters", {stall_cnt, bubble_cnt | flush_cnt}, 64'd0);
    #2 rst_n = 1'b1;
    #1;
    chk("t5.boot.dmem_go", {63'd0, dmem_go}, 64'd0);
    chk("t5.boot.imem_read", {63'd0, imem_read}, 64'd0);
    tick();
    chk("t5.fetch.dmem_go", {63'd0, dmem_go}, 64'd1);
    chk("t5.fetch.imem_read", {63'd0, imem_read}, 64'd1);

    // 6: 20 stall cycles; 4-bit counter saturates at 15
    mem_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 14) begin
        chk("t6.small15", {60'd0, s_stall_cnt}, 64'd15);
      end
    end
    chk("t6.small_sat", {60'd0, s_stall_cnt}, 64'd15);
    chk("t6.wide20", {32'd0, stall_cnt}, 64'd20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
